// File: rtl/rx_check_module.sv
// Receive-side packet checker: header decode, payload pattern check, error classification, stats.
// Optional per-priority good-packet counters are built only when RX_PRIO_CNT_EN is defined.
module rx_check_module #(
  parameter int unsigned RX_PORT        = 0,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WIDTH_SEL      = 2,
  parameter int unsigned WIDTH_PRIORITY = 2,
  parameter int unsigned WIDTH_LENGTH   = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_sop,
  input  logic                      rd_eop,
  input  logic                      rd_vld,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  input  logic                      rx_en,
  output logic                      ready,
  output logic                      pkt_done,
  output logic                      pkt_err,
  output logic [2:0]                err_code,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               err_cnt,
  output logic [15:0]               last_tag,
  output logic [WIDTH_PRIORITY-1:0] last_priority,
  output logic [WIDTH_LENGTH-1:0]   last_length,
  output logic [4*16-1:0]           prio_cnt
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PAYLOAD = 1'b1;

  localparam int unsigned CW = WIDTH_LENGTH + 1;
  localparam int unsigned PO = WIDTH_LENGTH;
  localparam int unsigned DO = WIDTH_LENGTH + WIDTH_PRIORITY;
  localparam int unsigned TO = WIDTH_LENGTH + WIDTH_PRIORITY + WIDTH_SEL;
  localparam logic [WIDTH_SEL-1:0] MY_PORT = WIDTH_SEL'(RX_PORT);

  localparam logic [2:0] E_NONE   = 3'd0;
  localparam logic [2:0] E_STRAY  = 3'd1;
  localparam logic [2:0] E_TRUNC  = 3'd2;
  localparam logic [2:0] E_LENGTH = 3'd3;
  localparam logic [2:0] E_DEST   = 3'd4;
  localparam logic [2:0] E_DATA   = 3'd5;

  logic [0:0]                state_q, state_d;
  logic                      ready_q;
  logic [15:0]               cur_tag_q, cur_tag_d;
  logic [WIDTH_PRIORITY-1:0] cur_prio_q, cur_prio_d;
  logic [WIDTH_LENGTH-1:0]   cur_len_q, cur_len_d;
  logic [2:0]                err_q, err_d;
  logic [CW-1:0]             cnt_q, cnt_d, cnt_sat;

  logic                      done_q;
  logic [2:0]                code_q;
  logic [15:0]               pkt_cnt_q, err_cnt_q;
  logic [15:0]               last_tag_q;
  logic [WIDTH_PRIORITY-1:0] last_prio_q;
  logic [WIDTH_LENGTH-1:0]   last_len_q;

  logic                      acc;
  logic [WIDTH_LENGTH-1:0]   hdr_len;
  logic [WIDTH_PRIORITY-1:0] hdr_prio;
  logic [WIDTH_SEL-1:0]      hdr_dest;
  logic [15:0]               hdr_tag;
  logic                      dest_bad;
  logic [DATA_WIDTH-1:0]     exp_word;
  logic                      data_bad;

  logic                      close;
  logic                      close_hdr;
  logic [2:0]                close_code;
  logic [15:0]               close_tag;
  logic [WIDTH_PRIORITY-1:0] close_prio;
  logic [WIDTH_LENGTH-1:0]   close_len;

  assign acc      = rd_vld & ready_q;
  assign hdr_len  = rd_data[WIDTH_LENGTH-1:0];
  assign hdr_prio = rd_data[PO +: WIDTH_PRIORITY];
  assign hdr_dest = rd_data[DO +: WIDTH_SEL];
  assign hdr_tag  = rd_data[TO +: 16];
  assign dest_bad = (hdr_dest != MY_PORT);

  // Saturating count keeps overlong packets from wrapping back onto the header length.
  assign cnt_sat  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
  assign exp_word = {{(DATA_WIDTH-16){1'b0}}, cur_tag_q + 16'(cnt_q)};
  assign data_bad = (cnt_q < {1'b0, cur_len_q}) && (rd_data != exp_word);

  always_comb begin
    state_d    = state_q;
    cur_tag_d  = cur_tag_q;
    cur_prio_d = cur_prio_q;
    cur_len_d  = cur_len_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    close      = 1'b0;
    close_hdr  = 1'b0;
    close_code = E_NONE;
    close_tag  = cur_tag_q;
    close_prio = cur_prio_q;
    close_len  = cur_len_q;

    if (acc) begin
      if (rd_sop) begin
        if (state_q == PAYLOAD) begin
          close      = 1'b1;
          close_hdr  = 1'b1;
          close_code = (err_q != E_NONE) ? err_q : E_TRUNC;
        end
        if (rd_eop || (hdr_len == '0)) begin
          // Header-only packet. If it lands on a truncated packet only the truncation is
          // reported, since a single cycle can carry just one pkt_done.
          state_d = IDLE;
          if (state_q == IDLE) begin
            close      = 1'b1;
            close_hdr  = 1'b1;
            close_tag  = hdr_tag;
            close_prio = hdr_prio;
            close_len  = hdr_len;
            if (dest_bad) begin
              close_code = E_DEST;
            end else if (hdr_len != '0) begin
              close_code = E_LENGTH;
            end
          end
        end else begin
          state_d    = PAYLOAD;
          cur_tag_d  = hdr_tag;
          cur_prio_d = hdr_prio;
          cur_len_d  = hdr_len;
          err_d      = dest_bad ? E_DEST : E_NONE;
          cnt_d      = '0;
        end
      end else if (state_q == IDLE) begin
        close      = 1'b1;
        close_code = E_STRAY;
      end else begin
        cnt_d = cnt_sat;
        if ((err_q == E_NONE) && data_bad) begin
          err_d = E_DATA;
        end
        if (rd_eop) begin
          state_d    = IDLE;
          close      = 1'b1;
          close_hdr  = 1'b1;
          if (err_d != E_NONE) begin
            close_code = err_d;
          end else if (cnt_sat != {1'b0, cur_len_q}) begin
            close_code = E_LENGTH;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      cur_tag_q  <= '0;
      cur_prio_q <= '0;
      cur_len_q  <= '0;
      err_q      <= E_NONE;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= rx_en;
      cur_tag_q  <= cur_tag_d;
      cur_prio_q <= cur_prio_d;
      cur_len_q  <= cur_len_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b0;
      code_q      <= E_NONE;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      last_tag_q  <= '0;
      last_prio_q <= '0;
      last_len_q  <= '0;
    end else begin
      done_q <= close;
      if (close) begin
        code_q <= close_code;
        if (close_code == E_NONE) begin
          if (pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end else begin
          if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
      end
      if (close_hdr) begin
        last_tag_q  <= close_tag;
        last_prio_q <= close_prio;
        last_len_q  <= close_len;
      end
    end
  end

`ifdef RX_PRIO_CNT_EN
  logic [15:0] prio_q [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 4; p++) prio_q[p] <= '0;
    end else if (close && (close_code == E_NONE)) begin
      for (int p = 0; p < 4; p++) begin
        if ((32'(close_prio) == 32'(p)) && (prio_q[p] != 16'hFFFF)) begin
          prio_q[p] <= prio_q[p] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_prio
    assign prio_cnt[16*g +: 16] = prio_q[g];
  end
`else
  assign prio_cnt = '0;
`endif

  assign ready         = ready_q;
  assign pkt_done      = done_q;
  assign pkt_err       = done_q & (code_q != E_NONE);
  assign err_code      = code_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign last_tag      = last_tag_q;
  assign last_priority = last_prio_q;
  assign last_length   = last_len_q;

endmodule

// File: tb/tb_rx_check_module.sv
// Directed bench for rx_check_module with RX_PORT=1; expected values are hand-computed.
module tb_rx_check_module;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_sop = 1'b0, rd_eop = 1'b0, rd_vld = 1'b0, rx_en = 1'b0;
  logic [31:0] rd_data = '0;
  logic        ready, pkt_done, pkt_err;
  logic [2:0]  err_code;
  logic [15:0] pkt_cnt, err_cnt, last_tag;
  logic [1:0]  last_priority;
  logic [6:0]  last_length;
  logic [63:0] prio_cnt;

  int n_run = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int d0;

  rx_check_module #(
    .RX_PORT(1), .DATA_WIDTH(32), .WIDTH_SEL(2), .WIDTH_PRIORITY(2), .WIDTH_LENGTH(7)
  ) dut (
    .clk(clk), .rst(rst), .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld),
    .rd_data(rd_data), .rx_en(rx_en), .ready(ready), .pkt_done(pkt_done),
    .pkt_err(pkt_err), .err_code(err_code), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
    .last_tag(last_tag), .last_priority(last_priority), .last_length(last_length),
    .prio_cnt(prio_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pkt_done === 1'b1) done_cnt = done_cnt + 1;

  function automatic logic [31:0] hdr(input logic [15:0] tag, input logic [1:0] dest,
                                      input logic [1:0] prio, input logic [6:0] len);
    return {5'b0, tag, dest, prio, len};
  endfunction

  task automatic send(input logic s, input logic e, input logic [31:0] d);
    @(negedge clk);
    rd_vld = 1'b1; rd_sop = s; rd_eop = e; rd_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0; rd_data = '0;
    end
  endtask

  task automatic send_payload(input logic [15:0] tag, input int n, input logic eop_last);
    for (int k = 0; k < n; k++) send(1'b0, eop_last && (k == n - 1), {16'h0, tag + 16'(k)});
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; rx_en = 1'b0; rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rx_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    n_run++;
    if ({ready, pkt_done, pkt_err, err_code} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 0", {ready, pkt_done, pkt_err, err_code});
    end
    n_run++;
    if ({pkt_cnt, err_cnt, last_tag, last_priority, last_length, prio_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_regs got cnt=%h err=%h tag=%h prio=%h len=%h pc=%h want 0",
                         pkt_cnt, err_cnt, last_tag, last_priority, last_length, prio_cnt);
    end
    do_reset;
    #1;
    n_run++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_en got %b want 1", ready); end
  endtask

  task automatic test_good;
    do_reset;
    d0 = done_cnt;
    send(1'b1, 1'b0, hdr(16'h0100, 2'd1, 2'd1, 7'd16));
    send_payload(16'h0100, 16, 1'b1);
    idle(1); #1;
    n_run++;
    if ({pkt_done, pkt_err, err_code} !== 5'b10000) begin
      n_fail++; $display("FAIL good_pulse got done=%b err=%b code=%0d want 1/0/0",
                         pkt_done, pkt_err, err_code);
    end
    n_run++;
    if (pkt_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL good_counts got pkt=%0d err=%0d want 1/0", pkt_cnt, err_cnt);
    end
    n_run++;
    if (last_length !== 7'd16 || last_tag !== 16'h0100 || last_priority !== 2'd1) begin
      n_fail++; $display("FAIL good_last got len=%0d tag=%h prio=%0d want 16/0100/1",
                         last_length, last_tag, last_priority);
    end
    idle(1); #1;
    n_run++;
    if (pkt_done !== 1'b0 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL good_one_pulse got done=%b pulses=%0d want 0/1",
                         pkt_done, done_cnt - d0);
    end
  endtask

  task automatic test_short;
    do_reset;
    send(1'b1, 1'b0, hdr(16'h0100, 2'd1, 2'd1, 7'd16));
    send_payload(16'h0100, 15, 1'b1);
    idle(1); #1;
    n_run++;
    if ({pkt_done, pkt_err, err_code} !== 5'b11011) begin
      n_fail++; $display("FAIL short_code got done=%b err=%b code=%0d want 1/1/3",
                         pkt_done, pkt_err, err_code);
    end
    n_run++;
    if (err_cnt !== 16'd1 || pkt_cnt !== 16'd0) begin
      n_fail++; $display("FAIL short_counts got pkt=%0d err=%0d want 0/1", pkt_cnt, err_cnt);
    end
  endtask

  task automatic test_truncation;
    do_reset;
    send(1'b1, 1'b0, hdr(16'h0200, 2'd1, 2'd0, 7'd20));
    send_payload(16'h0200, 6, 1'b0);
    send(1'b1, 1'b0, hdr(16'h0300, 2'd1, 2'd3, 7'd2));
    send(1'b0, 1'b0, 32'h0000_0300);
    #1;
    n_run++;
    if ({pkt_done, pkt_err, err_code} !== 5'b11010 || last_tag !== 16'h0200
        || last_length !== 7'd20) begin
      n_fail++; $display("FAIL trunc_code got done=%b err=%b code=%0d tag=%h len=%0d want 1/1/2/0200/20",
                         pkt_done, pkt_err, err_code, last_tag, last_length);
    end
    send(1'b0, 1'b1, 32'h0000_0301);
    idle(1); #1;
    n_run++;
    if ({pkt_done, pkt_err, err_code} !== 5'b10000) begin
      n_fail++; $display("FAIL trunc_next got done=%b err=%b code=%0d want 1/0/0",
                         pkt_done, pkt_err, err_code);
    end
    n_run++;
    if (pkt_cnt !== 16'd1 || err_cnt !== 16'd1 || last_tag !== 16'h0300 || last_priority !== 2'd3) begin
      n_fail++; $display("FAIL trunc_counts got pkt=%0d err=%0d tag=%h prio=%0d want 1/1/0300/3",
                         pkt_cnt, err_cnt, last_tag, last_priority);
    end
  endtask

  task automatic test_stray;
    do_reset;
    send(1'b0, 1'b0, 32'h0000_1234);
    idle(1); #1;
    n_run++;
    if ({pkt_done, pkt_err, err_code} !== 5'b11001 || err_cnt !== 16'd1) begin
      n_fail++; $display("FAIL stray_code got done=%b err=%b code=%0d errcnt=%0d want 1/1/1/1",
                         pkt_done, pkt_err, err_code, err_cnt);
    end
    n_run++;
    if (last_tag !== 16'h0 || last_length !== 7'd0) begin
      n_fail++; $display("FAIL stray_last got tag=%h len=%0d want 0/0", last_tag, last_length);
    end
    send(1'b1, 1'b1, hdr(16'h0055, 2'd1, 2'd0, 7'd0));
    idle(1); #1;
    n_run++;
    if ({pkt_done, err_code} !== 4'b1000 || pkt_cnt !== 16'd1 || last_tag !== 16'h0055) begin
      n_fail++; $display("FAIL stray_then_hdr got done=%b code=%0d pkt=%0d tag=%h want 1/0/1/0055",
                         pkt_done, err_code, pkt_cnt, last_tag);
    end
  endtask

  task automatic test_dest;
    do_reset;
    d0 = done_cnt;
    send(1'b1, 1'b0, hdr(16'h0400, 2'd2, 2'd0, 7'd3));
    send_payload(16'h0400, 2, 1'b0);
    #1;
    n_run++;
    if (done_cnt != d0) begin
      n_fail++; $display("FAIL dest_early got pulses=%0d want 0", done_cnt - d0);
    end
    send(1'b0, 1'b1, 32'h0000_0402);
    idle(1); #1;
    n_run++;
    if ({pkt_done, pkt_err, err_code} !== 5'b11100 || err_cnt !== 16'd1 || last_tag !== 16'h0400) begin
      n_fail++; $display("FAIL dest_code got done=%b err=%b code=%0d errcnt=%0d tag=%h want 1/1/4/1/0400",
                         pkt_done, pkt_err, err_code, err_cnt, last_tag);
    end
  endtask

  task automatic test_data_and_overlong;
    do_reset;
    d0 = done_cnt;
    send(1'b1, 1'b0, hdr(16'h0500, 2'd1, 2'd0, 7'd3));
    send(1'b0, 1'b0, 32'h0000_0500);
    send(1'b0, 1'b0, 32'h0000_dead);
    send(1'b0, 1'b1, 32'h0000_0502);
    idle(1); #1;
    n_run++;
    if ({pkt_done, err_code} !== 4'b1101 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL data_code got done=%b code=%0d pulses=%0d want 1/5/1",
                         pkt_done, err_code, done_cnt - d0);
    end
    send(1'b1, 1'b0, hdr(16'h0600, 2'd1, 2'd0, 7'd2));
    send_payload(16'h0600, 3, 1'b1);
    idle(1); #1;
    n_run++;
    if ({pkt_done, err_code} !== 4'b1011 || err_cnt !== 16'd2) begin
      n_fail++; $display("FAIL overlong_code got done=%b code=%0d errcnt=%0d want 1/3/2",
                         pkt_done, err_code, err_cnt);
    end
  endtask

  task automatic test_rx_en;
    do_reset;
    @(negedge clk);
    rx_en = 1'b0;
    #1;
    n_run++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_lag got %b want 1", ready); end
    @(negedge clk); #1;
    n_run++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_low got %b want 0", ready); end
    d0 = done_cnt;
    send(1'b0, 1'b0, 32'h0000_1234);
    send(1'b1, 1'b1, hdr(16'h0077, 2'd1, 2'd0, 7'd0));
    idle(2); #1;
    n_run++;
    if (done_cnt != d0 || pkt_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rx_off_ignored got pulses=%0d pkt=%0d err=%0d want 0/0/0",
                         done_cnt - d0, pkt_cnt, err_cnt);
    end
    rx_en = 1'b1;
  endtask

  task automatic test_reset_mid;
    do_reset;
    send(1'b1, 1'b1, hdr(16'h0700, 2'd1, 2'd2, 7'd0));
    send(1'b1, 1'b0, hdr(16'h0800, 2'd1, 2'd0, 7'd4));
    send_payload(16'h0800, 2, 1'b0);
    @(negedge clk);
    rst = 1'b1; rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0;
    #1;
    d0 = done_cnt;
    n_run++;
    if ({ready, pkt_done, pkt_err, err_code} !== 6'b0 || pkt_cnt !== 16'd0
        || last_tag !== 16'h0 || prio_cnt !== 64'h0) begin
      n_fail++; $display("FAIL rst_mid_clear got rdy=%b done=%b pkt=%0d tag=%h pc=%h want all 0",
                         ready, pkt_done, pkt_cnt, last_tag, prio_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_run++;
    if (done_cnt != d0) begin
      n_fail++; $display("FAIL rst_mid_nodone got pulses=%0d want 0", done_cnt - d0);
    end
    send(1'b0, 1'b1, 32'h0000_0802);
    idle(1); #1;
    n_run++;
    if ({pkt_done, err_code} !== 4'b1001) begin
      n_fail++; $display("FAIL rst_mid_stray got done=%b code=%0d want 1/1", pkt_done, err_code);
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) send(1'b1, 1'b1, hdr(16'h0010 + 16'(i), 2'd1, 2'd2, 7'd0));
    idle(1); #1;
    n_run++;
    if (pkt_done !== 1'b1 || done_cnt - d0 != 3 || pkt_cnt !== 16'd3 || last_tag !== 16'h0012) begin
      n_fail++; $display("FAIL b2b_pulses got done=%b pulses=%0d pkt=%0d tag=%h want 1/3/3/0012",
                         pkt_done, done_cnt - d0, pkt_cnt, last_tag);
    end
    n_run++;
`ifdef RX_PRIO_CNT_EN
    if (prio_cnt !== {16'd0, 16'd3, 16'd0, 16'd0}) begin
      n_fail++; $display("FAIL prio_cnt got %h want 0000000300000000", prio_cnt);
    end
`else
    if (prio_cnt !== 64'h0) begin
      n_fail++; $display("FAIL prio_cnt got %h want 0", prio_cnt);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_good;
    test_short;
    test_truncation;
    test_stray;
    test_dest;
    test_data_and_overlong;
    test_rx_en;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_check_module.md
RX_CHECK_MODULE -- requirements
Module: rx_check_module

Interface
REQ-001 SHALL have parameter RX_PORT, default 0: port index this checker receives for.
REQ-002 SHALL have parameter DATA_WIDTH, default 32 (>=32): beat width.
REQ-003 SHALL have parameter WIDTH_SEL, default 2: port-index field width.
REQ-004 SHALL have parameter WIDTH_PRIORITY, default 2: priority field width.
REQ-005 SHALL have parameter WIDTH_LENGTH, default 7: payload-length field width.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have ports rd_sop, rd_eop, rd_vld, input, 1 each: packet start, packet end, beat valid.
REQ-009 SHALL have port rd_data, input, DATA_WIDTH: beat data.
REQ-010 SHALL have port rx_en, input, 1: software request to accept traffic.
REQ-011 SHALL have port ready, output, 1: accepting beats (drives switch per-port ready).
REQ-012 SHALL have ports pkt_done, pkt_err, output, 1 each: end-of-packet pulse, error qualifier.
REQ-013 SHALL have port err_code, output, 3: first error of last packet.
REQ-014 SHALL have ports pkt_cnt, err_cnt, output, 16 each: good-packet and error counters.
REQ-015 SHALL have ports last_tag (16), last_priority (WIDTH_PRIORITY), last_length (WIDTH_LENGTH), outputs: header fields of last finished packet.
REQ-016 SHALL have port prio_cnt, output, 4*16: per-priority good-packet counters.

Function
REQ-017 ready SHALL be rx_en registered one cycle; a beat is accepted only when rd_vld & ready; rd_sop/rd_eop ignored without rd_vld.
REQ-018 Header beat (sop) layout SHALL be: [WIDTH_LENGTH-1:0] length, next WIDTH_PRIORITY bits priority, next WIDTH_SEL bits dest, next 16 bits tag; remaining bits ignored.
REQ-019 Payload beat k (k=0..length-1) SHALL equal {zeros, (tag+k) mod 2^16}.
REQ-020 FSM states SHALL be IDLE, PAYLOAD; IDLE->PAYLOAD on accepted sop without eop and length!=0; PAYLOAD->IDLE on accepted eop.
REQ-021 Accepted sop+eop in one beat SHALL be a complete header-only packet; valid only if length==0.
REQ-022 Error codes (first detected wins, held until pkt_done): 1 stray beat in IDLE without sop; 2 sop in PAYLOAD (truncation); 3 beat count != length at eop; 4 dest != RX_PORT; 5 payload data mismatch.
REQ-023 Stray beat (code 1) SHALL pulse pkt_done+pkt_err the next cycle, stay IDLE, not touch last_* fields.
REQ-024 Sop in PAYLOAD SHALL close the old packet with code 2 (pulse next cycle) and simultaneously start the new one from its header.
REQ-025 Dest mismatch and data mismatch SHALL NOT abort reception; the packet is consumed to eop.
REQ-026 pkt_done SHALL pulse exactly one cycle, one cycle after the closing beat; pkt_err, err_code valid in same cycle; err_code 0 when no error.
REQ-027 On good packet pkt_cnt increments; on error err_cnt increments; both saturate at 16'hFFFF.
REQ-028 last_* SHALL update with every pkt_done whose header was received.
REQ-029 Payload beat counter SHALL be WIDTH_LENGTH+1 bits and saturate, so overlong packets give code 3, never wrap to match.

Reset
REQ-030 On rst: FSM IDLE, ready 0, pkt_done 0, pkt_err 0, err_code 0, all counters 0, last_* 0, prio_cnt 0.
REQ-031 Reset mid-packet SHALL discard the packet with no pkt_done; first beat after reset must be a sop.

Configuration
REQ-032 Macro RX_PRIO_CNT_EN defined: prio_cnt[16*p+15:16*p] counts good packets of priority p (p<4), saturating.
REQ-033 Macro RX_PRIO_CNT_EN undefined: prio_cnt tied to 0, no counter registers.

Verification
REQ-034 RX_PORT=1; header tag=0x0100, dest 1, prio 1, length 16, payload 0x0100..0x010F, eop on last -> one pkt_done, pkt_err 0, pkt_cnt 1, last_length 16.
REQ-035 Same header, eop after 15 payload beats -> pkt_err 1, err_code 3, err_cnt 1.
REQ-036 Packet length 20, sop arrives after payload beat 5 -> code 2 pulse, then new packet completes good; pkt_cnt 1, err_cnt 1.
REQ-037 rd_vld with no sop in IDLE -> code 1 pulse; dest 2 with RX_PORT 1 -> code 4 at eop only.
REQ-038 rx_en low: ready low next cycle, beats ignored; rst asserted mid-packet -> all outputs 0, no pkt_done; with RX_PRIO_CNT_EN, three prio-2 good packets -> prio_cnt[47:32]=3.
